// File: rtl/mem_access_stage.sv
// MEM pipeline stage: decodes the EX/MEM opcode, issues one data-memory
// request at a time, and loads the MEM/WB register on completion.
//
// Handshake: upstream presents an instruction with in_valid=1. The stage takes
// it on any rising edge where stall=0, and upstream must hold in_* stable for
// as long as stall=1. A memory request is held (dm_req=1, dm_* constant) until
// the first cycle with dm_ack=1. That cycle completes it, and dm_rdata is
// sampled in that same cycle.
module mem_access_stage (
  input  logic        clk,
  input  logic        reset,
  input  logic        in_valid,
  input  logic [5:0]  in_ir,
  input  logic [31:0] in_addr,
  input  logic [31:0] in_rt,
  output logic        stall,
  output logic        dm_req,
  output logic        dm_we,
  output logic [31:0] dm_addr,
  output logic [3:0]  dm_be,
  output logic [31:0] dm_wdata,
  input  logic        dm_ack,
  input  logic [31:0] dm_rdata,
  output logic        wb_valid,
  output logic [31:0] wb_mem_data,
  output logic [1:0]  wb_addr_lo,
  output logic [5:0]  wb_ir,
  output logic        exc_adel,
  output logic        exc_ades,
  output logic        dbg_busy
);

  localparam logic [5:0] OP_LB  = 6'b100000;
  localparam logic [5:0] OP_LH  = 6'b100001;
  localparam logic [5:0] OP_LWL = 6'b100010;
  localparam logic [5:0] OP_LW  = 6'b100011;
  localparam logic [5:0] OP_LBU = 6'b100100;
  localparam logic [5:0] OP_LHU = 6'b100101;
  localparam logic [5:0] OP_LWR = 6'b100110;
  localparam logic [5:0] OP_SB  = 6'b101000;
  localparam logic [5:0] OP_SH  = 6'b101001;
  localparam logic [5:0] OP_SWL = 6'b101010;
  localparam logic [5:0] OP_SW  = 6'b101011;
  localparam logic [5:0] OP_SWR = 6'b101110;

  typedef enum logic {IDLE = 1'b0, BUSY = 1'b1} state_t;

  state_t      state_q, state_d;
  logic        dm_req_q, dm_req_d;
  logic        dm_we_q, dm_we_d;
  logic [31:0] dm_addr_q, dm_addr_d;
  logic [3:0]  dm_be_q, dm_be_d;
  logic [31:0] dm_wdata_q, dm_wdata_d;
  logic [5:0]  req_ir_q, req_ir_d;
  logic [1:0]  req_lo_q, req_lo_d;
  logic        req_load_q, req_load_d;
  logic        wb_valid_q, wb_valid_d;
  logic [31:0] wb_mem_data_q, wb_mem_data_d;
  logic [1:0]  wb_addr_lo_q, wb_addr_lo_d;
  logic [5:0]  wb_ir_q, wb_ir_d;
  logic        exc_adel_q, exc_adel_d;
  logic        exc_ades_q, exc_ades_d;

  logic [1:0]  off;
  logic        is_load, is_store, misal, accept;
  logic [3:0]  st_be;
  logic [31:0] st_wdata;

  assign off = in_addr[1:0];

  // Opcode decode, alignment check and big-endian store lane steering.
  always_comb begin
    is_load  = 1'b0;
    is_store = 1'b0;
    misal    = 1'b0;
    st_be    = 4'b0000;
    st_wdata = 32'h0;
    case (in_ir)
      OP_LB, OP_LBU, OP_LWL, OP_LWR: is_load = 1'b1;
      OP_LH, OP_LHU: begin
        is_load = 1'b1;
        misal   = off[0];
      end
      OP_LW: begin
        is_load = 1'b1;
        misal   = |off;
      end
      OP_SB: begin
        is_store = 1'b1;
        st_be    = 4'b1000 >> off;
        st_wdata = {4{in_rt[7:0]}};
      end
      OP_SH: begin
        is_store = 1'b1;
        misal    = off[0];
        st_be    = off[1] ? 4'b0011 : 4'b1100;
        st_wdata = {2{in_rt[15:0]}};
      end
      OP_SW: begin
        is_store = 1'b1;
        misal    = |off;
        st_be    = 4'b1111;
        st_wdata = in_rt;
      end
      OP_SWL: begin
        is_store = 1'b1;
        st_be    = 4'b1111 >> off;
        st_wdata = in_rt >> {off, 3'b000};
      end
      OP_SWR: begin
        // For a 2-bit offset, (3 - off) is the same as ~off.
        is_store = 1'b1;
        st_be    = 4'b1111 << ~off;
        st_wdata = in_rt << {~off, 3'b000};
      end
      default: ;
    endcase
    accept = in_valid & (is_load | is_store) & ~misal;
  end

  // Stall is combinational so the accepting cycle already holds upstream.
  // It is forced low while reset is asserted.
  always_comb begin
    if (reset)
      stall = 1'b0;
    else if (state_q == IDLE)
      stall = accept;
    else
      stall = ~dm_ack;
  end

  // Next-state logic for the FSM, the request registers and MEM/WB.
  always_comb begin
    state_d       = state_q;
    dm_req_d      = dm_req_q;
    dm_we_d       = dm_we_q;
    dm_addr_d     = dm_addr_q;
    dm_be_d       = dm_be_q;
    dm_wdata_d    = dm_wdata_q;
    req_ir_d      = req_ir_q;
    req_lo_d      = req_lo_q;
    req_load_d    = req_load_q;
    wb_valid_d    = 1'b0;
    wb_mem_data_d = wb_mem_data_q;
    wb_addr_lo_d  = wb_addr_lo_q;
    wb_ir_d       = wb_ir_q;
    exc_adel_d    = 1'b0;
    exc_ades_d    = 1'b0;
    case (state_q)
      IDLE: begin
        if (accept) begin
          state_d    = BUSY;
          dm_req_d   = 1'b1;
          dm_we_d    = is_store;
          dm_addr_d  = {in_addr[31:2], 2'b00};
          dm_be_d    = st_be;
          dm_wdata_d = st_wdata;
          req_ir_d   = in_ir;
          req_lo_d   = off;
          req_load_d = is_load;
        end else if (in_valid) begin
          wb_valid_d    = 1'b1;
          wb_mem_data_d = 32'h0;
          wb_addr_lo_d  = off;
          wb_ir_d       = in_ir;
          exc_adel_d    = misal & is_load;
          exc_ades_d    = misal & is_store;
        end
      end
      BUSY: begin
        if (dm_ack) begin
          state_d       = IDLE;
          dm_req_d      = 1'b0;
          dm_we_d       = 1'b0;
          dm_addr_d     = 32'h0;
          dm_be_d       = 4'b0000;
          dm_wdata_d    = 32'h0;
          wb_valid_d    = 1'b1;
          wb_mem_data_d = req_load_q ? dm_rdata : 32'h0;
          wb_addr_lo_d  = req_lo_q;
          wb_ir_d       = req_ir_q;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // State registers. Reset clears everything at once, which also drops any
  // request that is in flight.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q       <= IDLE;
      dm_req_q      <= 1'b0;
      dm_we_q       <= 1'b0;
      dm_addr_q     <= 32'h0;
      dm_be_q       <= 4'b0000;
      dm_wdata_q    <= 32'h0;
      req_ir_q      <= 6'h0;
      req_lo_q      <= 2'b00;
      req_load_q    <= 1'b0;
      wb_valid_q    <= 1'b0;
      wb_mem_data_q <= 32'h0;
      wb_addr_lo_q  <= 2'b00;
      wb_ir_q       <= 6'h0;
      exc_adel_q    <= 1'b0;
      exc_ades_q    <= 1'b0;
    end else begin
      state_q       <= state_d;
      dm_req_q      <= dm_req_d;
      dm_we_q       <= dm_we_d;
      dm_addr_q     <= dm_addr_d;
      dm_be_q       <= dm_be_d;
      dm_wdata_q    <= dm_wdata_d;
      req_ir_q      <= req_ir_d;
      req_lo_q      <= req_lo_d;
      req_load_q    <= req_load_d;
      wb_valid_q    <= wb_valid_d;
      wb_mem_data_q <= wb_mem_data_d;
      wb_addr_lo_q  <= wb_addr_lo_d;
      wb_ir_q       <= wb_ir_d;
      exc_adel_q    <= exc_adel_d;
      exc_ades_q    <= exc_ades_d;
    end
  end

  assign dm_req      = dm_req_q;
  assign dm_we       = dm_we_q;
  assign dm_addr     = dm_addr_q;
  assign dm_be       = dm_be_q;
  assign dm_wdata    = dm_wdata_q;
  assign wb_valid    = wb_valid_q;
  assign wb_mem_data = wb_mem_data_q;
  assign wb_addr_lo  = wb_addr_lo_q;
  assign wb_ir       = wb_ir_q;
  assign exc_adel    = exc_adel_q;
  assign exc_ades    = exc_ades_q;
  assign dbg_busy    = (state_q == BUSY);

endmodule

// File: tb/tb_mem_access_stage.sv
// Directed bench for mem_access_stage. Every expected value below is worked
// out by hand.
module tb_mem_access_stage;

  logic        clk = 1'b0;
  logic        reset = 1'b0;
  logic        in_valid = 1'b0;
  logic [5:0]  in_ir = 6'h0;
  logic [31:0] in_addr = 32'h0;
  logic [31:0] in_rt = 32'h0;
  logic        stall, dm_req, dm_we;
  logic [31:0] dm_addr, dm_wdata;
  logic [3:0]  dm_be;
  logic        dm_ack = 1'b0;
  logic [31:0] dm_rdata = 32'h0;
  logic        wb_valid;
  logic [31:0] wb_mem_data;
  logic [1:0]  wb_addr_lo;
  logic [5:0]  wb_ir;
  logic        exc_adel, exc_ades, dbg_busy;

  int n_assert = 0;
  int n_fail   = 0;
  int stall_cnt;

  mem_access_stage dut (
    .clk(clk), .reset(reset), .in_valid(in_valid), .in_ir(in_ir),
    .in_addr(in_addr), .in_rt(in_rt), .stall(stall), .dm_req(dm_req),
    .dm_we(dm_we), .dm_addr(dm_addr), .dm_be(dm_be), .dm_wdata(dm_wdata),
    .dm_ack(dm_ack), .dm_rdata(dm_rdata), .wb_valid(wb_valid),
    .wb_mem_data(wb_mem_data), .wb_addr_lo(wb_addr_lo), .wb_ir(wb_ir),
    .exc_adel(exc_adel), .exc_ades(exc_ades), .dbg_busy(dbg_busy)
  );

  // Clock generation.
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Advance to just after the next rising edge.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic present(input logic [5:0] ir, input logic [31:0] addr, input logic [31:0] rt);
    in_valid = 1'b1;
    in_ir    = ir;
    in_addr  = addr;
    in_rt    = rt;
  endtask

  // Single memory op acked in its first BUSY cycle. The request fields and
  // the write-back results are checked against hand-computed values.
  task automatic mem_op(input string tag, input logic [5:0] ir, input logic [31:0] addr,
                        input logic [31:0] rt, input logic [31:0] rdata,
                        input logic exp_we, input logic [3:0] exp_be,
                        input logic [31:0] exp_daddr, input logic [31:0] exp_wdata,
                        input logic [31:0] exp_wb);
    present(ir, addr, rt);
    #1;
    chk({tag, "_stall_issue"}, 32'(stall), 32'd1);
    chk({tag, "_no_req_idle"}, 32'(dm_req), 32'd0);
    tick();
    chk({tag, "_dm_req"}, 32'(dm_req), 32'd1);
    chk({tag, "_dm_we"}, 32'(dm_we), 32'(exp_we));
    chk({tag, "_dm_be"}, 32'(dm_be), 32'(exp_be));
    chk({tag, "_dm_addr"}, dm_addr, exp_daddr);
    chk({tag, "_dm_wdata"}, dm_wdata, exp_wdata);
    dm_ack   = 1'b1;
    dm_rdata = rdata;
    #1;
    chk({tag, "_stall_ack"}, 32'(stall), 32'd0);
    tick();
    dm_ack   = 1'b0;
    in_valid = 1'b0;
    #1;
    chk({tag, "_wb_valid"}, 32'(wb_valid), 32'd1);
    chk({tag, "_wb_data"}, wb_mem_data, exp_wb);
    chk({tag, "_wb_lo"}, 32'(wb_addr_lo), 32'(addr[1:0]));
    chk({tag, "_wb_ir"}, 32'(wb_ir), 32'(ir));
    chk({tag, "_exc"}, 32'({exc_adel, exc_ades}), 32'd0);
    chk({tag, "_req_drop"}, 32'(dm_req), 32'd0);
  endtask

  initial begin
    // Reset is applied while a valid LW is presented, so that stall must
    // also be held low during reset.
    present(6'b100011, 32'h0000_1008, 32'h0);
    #1 reset = 1'b1;
    #1;
    chk("rst_stall", 32'(stall), 32'd0);
    chk("rst_dm_req", 32'(dm_req), 32'd0);
    chk("rst_dm_we", 32'(dm_we), 32'd0);
    chk("rst_dm_be", 32'(dm_be), 32'd0);
    chk("rst_dm_addr", dm_addr, 32'd0);
    chk("rst_dm_wdata", dm_wdata, 32'd0);
    chk("rst_wb_valid", 32'(wb_valid), 32'd0);
    chk("rst_wb_data", wb_mem_data, 32'd0);
    chk("rst_wb_lo", 32'(wb_addr_lo), 32'd0);
    chk("rst_wb_ir", 32'(wb_ir), 32'd0);
    chk("rst_exc", 32'({exc_adel, exc_ades}), 32'd0);
    chk("rst_busy", 32'(dbg_busy), 32'd0);
    in_valid = 1'b0;
    tick();
    tick();
    reset = 1'b0;
    tick();
    chk("idle_wb_valid", 32'(wb_valid), 32'd0);

    // LW at 0x1008, acked 3 cycles after dm_req: 4 stall cycles, then write-back.
    present(6'b100011, 32'h0000_1008, 32'h0);
    stall_cnt = 0;
    #1;
    if (stall) stall_cnt++;
    tick();
    chk("lw_dm_req", 32'(dm_req), 32'd1);
    chk("lw_dm_addr", dm_addr, 32'h0000_1008);
    chk("lw_dm_we", 32'(dm_we), 32'd0);
    chk("lw_dm_be", 32'(dm_be), 32'd0);
    if (stall) stall_cnt++;
    tick();
    chk("lw_wait_wb", 32'(wb_valid), 32'd0);
    chk("lw_wait_req", 32'(dm_req), 32'd1);
    if (stall) stall_cnt++;
    tick();
    if (stall) stall_cnt++;
    tick();
    dm_ack   = 1'b1;
    dm_rdata = 32'hDEAD_BEEF;
    #1;
    if (stall) stall_cnt++;
    chk("lw_stall_cycles", 32'(stall_cnt), 32'd4);
    tick();
    dm_ack   = 1'b0;
    in_valid = 1'b0;
    #1;
    chk("lw_wb_valid", 32'(wb_valid), 32'd1);
    chk("lw_wb_data", wb_mem_data, 32'hDEAD_BEEF);
    chk("lw_wb_lo", 32'(wb_addr_lo), 32'd0);
    chk("lw_wb_ir", 32'(wb_ir), 32'b100011);
    chk("lw_req_drop", 32'(dm_req), 32'd0);
    tick();
    chk("lw_wb_pulse", 32'(wb_valid), 32'd0);

    // Store lane steering; for stores the write-back data must be 0 even
    // though dm_rdata carries a value.
    mem_op("sb", 6'b101000, 32'h0000_2002, 32'h1234_56AB, 32'h5555_5555,
           1'b1, 4'b0010, 32'h0000_2000, 32'hABAB_ABAB, 32'h0);
    mem_op("swl", 6'b101010, 32'h0000_3001, 32'hAABB_CCDD, 32'h0,
           1'b1, 4'b0111, 32'h0000_3000, 32'h00AA_BBCC, 32'h0);
    mem_op("swr", 6'b101110, 32'h0000_3001, 32'hAABB_CCDD, 32'h0,
           1'b1, 4'b1100, 32'h0000_3000, 32'hCCDD_0000, 32'h0);
    mem_op("sh2", 6'b101001, 32'h0000_3102, 32'h1234_ABCD, 32'h0,
           1'b1, 4'b0011, 32'h0000_3100, 32'hABCD_ABCD, 32'h0);
    mem_op("sw", 6'b101011, 32'h0000_3204, 32'h0102_0304, 32'h0,
           1'b1, 4'b1111, 32'h0000_3204, 32'h0102_0304, 32'h0);
    mem_op("sb3", 6'b101000, 32'h0000_3303, 32'h0000_0077, 32'h0,
           1'b1, 4'b0001, 32'h0000_3300, 32'h7777_7777, 32'h0);
    mem_op("lbu", 6'b100100, 32'h0000_3401, 32'h0, 32'h1122_3344,
           1'b0, 4'b0000, 32'h0000_3400, 32'h0, 32'h1122_3344);

    // Misaligned LH: no request, no stall, one-cycle exc_adel.
    present(6'b100001, 32'h0000_4003, 32'h0);
    #1;
    chk("lh_mis_stall", 32'(stall), 32'd0);
    tick();
    in_valid = 1'b0;
    #1;
    chk("lh_mis_req", 32'(dm_req), 32'd0);
    chk("lh_mis_wb", 32'(wb_valid), 32'd1);
    chk("lh_mis_adel", 32'(exc_adel), 32'd1);
    chk("lh_mis_ades", 32'(exc_ades), 32'd0);
    chk("lh_mis_data", wb_mem_data, 32'd0);
    chk("lh_mis_lo", 32'(wb_addr_lo), 32'd3);
    tick();
    chk("lh_mis_pulse", 32'(exc_adel), 32'd0);

    // Misaligned SW: exc_ades only.
    present(6'b101011, 32'h0000_4102, 32'h0);
    #1;
    chk("sw_mis_stall", 32'(stall), 32'd0);
    tick();
    in_valid = 1'b0;
    #1;
    chk("sw_mis_req", 32'(dm_req), 32'd0);
    chk("sw_mis_ades", 32'(exc_ades), 32'd1);
    chk("sw_mis_adel", 32'(exc_adel), 32'd0);
    tick();
    chk("sw_mis_pulse", 32'(exc_ades), 32'd0);

    // ADD, then LW back-to-back; the LW is acked one cycle late.
    present(6'b000000, 32'h0000_0005, 32'h0);
    #1;
    chk("add_stall", 32'(stall), 32'd0);
    tick();
    present(6'b100011, 32'h0000_500C, 32'h0);
    #1;
    chk("add_wb_valid", 32'(wb_valid), 32'd1);
    chk("add_wb_ir", 32'(wb_ir), 32'd0);
    chk("add_wb_lo", 32'(wb_addr_lo), 32'd1);
    chk("b2b_lw_stall", 32'(stall), 32'd1);
    tick();
    chk("b2b_lw_req", 32'(dm_req), 32'd1);
    chk("b2b_lw_addr", dm_addr, 32'h0000_500C);
    chk("b2b_wait_wb", 32'(wb_valid), 32'd0);
    chk("b2b_wait_stall", 32'(stall), 32'd1);
    tick();
    dm_ack   = 1'b1;
    dm_rdata = 32'hCAFE_F00D;
    #1;
    chk("b2b_wait2_wb", 32'(wb_valid), 32'd0);
    chk("b2b_ack_stall", 32'(stall), 32'd0);
    tick();
    dm_ack   = 1'b0;
    in_valid = 1'b0;
    #1;
    chk("b2b_lw_wb", 32'(wb_valid), 32'd1);
    chk("b2b_lw_data", wb_mem_data, 32'hCAFE_F00D);
    chk("b2b_lw_ir", 32'(wb_ir), 32'b100011);

    // Reset during a BUSY wait drops everything at once; the next LW issues normally.
    present(6'b100011, 32'h0000_6000, 32'h0);
    tick();
    chk("rb_req_before", 32'(dm_req), 32'd1);
    tick();
    reset = 1'b1;
    #1;
    chk("rb_req", 32'(dm_req), 32'd0);
    chk("rb_stall", 32'(stall), 32'd0);
    chk("rb_wb", 32'(wb_valid), 32'd0);
    chk("rb_busy", 32'(dbg_busy), 32'd0);
    dm_ack   = 1'b1;
    dm_rdata = 32'hBAD0_BAD0;
    tick();
    chk("rb_wb_hold", 32'(wb_valid), 32'd0);
    dm_ack = 1'b0;
    reset  = 1'b0;
    present(6'b100011, 32'h0000_7004, 32'h0);
    #1;
    chk("rb_post_wb", 32'(wb_valid), 32'd0);
    mem_op("rb_lw", 6'b100011, 32'h0000_7004, 32'h0, 32'h0BAD_F00D,
           1'b0, 4'b0000, 32'h0000_7004, 32'h0, 32'h0BAD_F00D);

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule

// File: doc/mem_access_stage.md
MEM_ACCESS_STAGE -- requirements
Module: mem_access_stage

Interface
REQ-001 clk  input  1  single clock; all state updates on rising edge.
REQ-002 reset  input  1  asynchronous, active-high reset.
REQ-003 in_valid  input  1  EX/MEM instruction present this cycle.
REQ-004 in_ir  input  6  opcode IR[31:26] of presented instruction.
REQ-005 in_addr  input  32  effective byte address from ALU.
REQ-006 in_rt  input  32  store source register value.
REQ-007 stall  output  1  upstream holds in_* stable while high.
REQ-008 dm_req, dm_we  output  1 each  memory request / write qualifier.
REQ-009 dm_addr  output  32  word address, bits [1:0] always 00.
REQ-010 dm_be  output  4  byte write enables, bit3 = lane [31:24] (big-endian, byte offset 0).
REQ-011 dm_wdata  output  32  aligned store data.
REQ-012 dm_ack  input  1  memory completes held request this cycle.
REQ-013 dm_rdata  input  32  read word, valid when dm_ack=1.
REQ-014 wb_valid  output  1  MEM/WB register valid.
REQ-015 wb_mem_data  output  32  raw read word to the load alignment stage.
REQ-016 wb_addr_lo  output  2  in_addr[1:0] of completed instruction.
REQ-017 wb_ir  output  6  opcode of completed instruction.
REQ-018 exc_adel, exc_ades  output  1 each  misaligned load / store flag, one-cycle pulse with wb_valid.

Function
REQ-019 Decode: loads LB 100000, LH 100001, LWL 100010, LW 100011, LBU 100100, LHU 100101, LWR 100110; stores SB 101000, SH 101001, SWL 101010, SW 101011, SWR 101110; all other opcodes are non-memory.
REQ-020 Misaligned: LH/LHU/SH with addr[0]=1; LW/SW with addr[1:0]!=00; no memory request issued.
REQ-021 States: IDLE, BUSY.
REQ-022 IDLE, in_valid, aligned memory op: register dm_* fields, go BUSY; stall=1 combinationally that cycle.
REQ-023 IDLE, in_valid, non-memory or misaligned op: next edge loads wb_* (wb_valid=1, wb_mem_data=0), stays IDLE, stall=0; misaligned asserts exc_adel/exc_ades.
REQ-024 IDLE, in_valid=0: next edge wb_valid=0.
REQ-025 BUSY: dm_req=1, dm_* constant; in_* ignored; stall = !dm_ack.
REQ-026 BUSY with dm_ack: next edge wb_valid=1, wb_mem_data=dm_rdata for loads (0 for stores), wb_addr_lo/wb_ir from the registered request, state IDLE.
REQ-027 BUSY without dm_ack: wb_valid=0 each cycle; no timeout.
REQ-028 Latency: non-memory 1 cycle; memory op = 1 + cycles until dm_ack (minimum 2).
REQ-029 dm_we=1 only for stores; loads drive dm_be=0000.
REQ-030 SB: wdata={4{rt[7:0]}}, be offsets 0..3 = 1000/0100/0010/0001.
REQ-031 SH: wdata={2{rt[15:0]}}, be offset 0 = 1100, offset 2 = 0011.
REQ-032 SW: wdata=rt, be=1111.
REQ-033 SWL: wdata=rt >> (8*offset), be offsets 0..3 = 1111/0111/0011/0001.
REQ-034 SWR: wdata=rt << (8*(3-offset)), be offsets 0..3 = 1000/1100/1110/1111.
REQ-035 exc_adel, exc_ades are never both 1; both 0 for completed memory ops.
REQ-036 dm_req is never 1 in IDLE.

Reset
REQ-037 reset: state IDLE; all outputs 0 (stall, dm_req, dm_we, dm_be, dm_addr, dm_wdata, wb_*, exc_*) immediately, without waiting for a clock edge.
REQ-038 reset during BUSY drops dm_req immediately and discards the transaction; no wb_valid results from it.

Verification
REQ-039 LW addr 0x0000_1008, dm_ack 3 cycles after dm_req, dm_rdata 0xDEADBEEF -> dm_addr 0x1008, stall high 4 cycles, then wb_valid=1, wb_mem_data=0xDEADBEEF, wb_addr_lo=0.
REQ-040 SB addr 0x...0002, rt 0x1234_56AB, ack same cycle -> dm_wdata 0xABABABAB, dm_be 0010, dm_we=1, completion 2 cycles after presentation.
REQ-041 SWL offset 1, rt 0xAABBCCDD -> wdata 0x00AABBCC, be 0111; SWR offset 1 -> wdata 0xCCDD0000, be 1100.
REQ-042 LH addr ...0x3 -> no dm_req, stall=0, next cycle wb_valid=1 and exc_adel=1 for one cycle; SW addr ...0x2 -> exc_ades=1.
REQ-043 ADD opcode 000000 back-to-back with LW, LW acked 1 cycle late -> ADD completes in 1 cycle, LW stalls until ack, in-order wb_valid pulses.
REQ-044 reset asserted in BUSY mid-wait -> dm_req, stall, wb_valid 0 at once; after release, the next LW issues normally.
